// File: rtl/conv_encoder_frame.sv
// Frame-oriented rate-1/2 mother convolutional encoder with start/length
// framing, valid/ready handshakes, programmable puncturing (1/2, 2/3, 3/4)
// and either zero-tail termination or tail-biting via state preload.
module conv_encoder_frame #(
  parameter int K      = 7,
  parameter int G0_OCT = 32'o171,
  parameter int G1_OCT = 32'o133,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [1:0]       mode,
  input  logic             tail_biting,
  input  logic [K-2:0]     seed_value,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sym,
  output logic [1:0]       out_mask,
  output logic             out_last,
  output logic             busy
);

  localparam int M  = K - 1;
  localparam int TW = $clog2(M + 1);
  localparam logic [K-1:0] G0_MASK = G0_OCT[K-1:0];
  localparam logic [K-1:0] G1_MASK = G1_OCT[K-1:0];

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2, DRAIN = 2'd3} state_t;

  // Keep flags for the given rate and puncture phase; never 00.
  function automatic logic [1:0] punct_mask(input logic [1:0] md, input logic [1:0] ph);
    logic [1:0] m;
    m = 2'b11;
    case (md)
      2'd1:    m = (ph == 2'd1) ? 2'b10 : 2'b11;
      2'd2: begin
        case (ph)
          2'd1:    m = 2'b10;
          2'd2:    m = 2'b01;
          default: m = 2'b11;
        endcase
      end
      default: m = 2'b11;
    endcase
    return m;
  endfunction

  // Puncture phase after one data beat; wraps at the pattern period.
  function automatic logic [1:0] phase_next(input logic [1:0] md, input logic [1:0] ph);
    logic [1:0] nx;
    nx = 2'd0;
    case (md)
      2'd1:    nx = (ph == 2'd1) ? 2'd0 : ph + 2'd1;
      2'd2:    nx = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
      default: nx = 2'd0;
    endcase
    return nx;
  endfunction

  state_t           state, next_state;
  logic [M-1:0]     enc_state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [TW-1:0]    tail_cnt;
  logic [1:0]       mode_r;
  logic [1:0]       phase;
  logic             tb_r;

  logic             slot_free, take_data, take_tail, gen;
  logic             gen_bit, last_data, tail_done, beat_last;
  logic [K-1:0]     reg_vec;
  logic [1:0]       sym_raw, mask_s;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == DATA) && slot_free;
  assign busy      = (state != IDLE);
  assign take_data = (state == DATA) && in_valid && slot_free;
  assign take_tail = (state == TAIL) && slot_free;
  assign gen       = take_data || take_tail;
  assign gen_bit   = take_data ? in_bit : 1'b0;
  assign last_data = (cnt == len_r - LEN_W'(1));
  assign tail_done = (tail_cnt == TW'(M - 1));
  assign reg_vec   = {gen_bit, enc_state};
  assign sym_raw   = {^(reg_vec & G0_MASK), ^(reg_vec & G1_MASK)};
  // Tail beats are never punctured.
  assign mask_s    = take_tail ? 2'b11 : punct_mask(mode_r, phase);
  assign beat_last = take_tail ? tail_done : (last_data && tb_r);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame sequencing: data bits, optional zero tail, then wait for the last beat.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = DATA;
        else       next_state = IDLE;
      end
      DATA: begin
        if (take_data && last_data) next_state = tb_r ? DRAIN : TAIL;
        else                        next_state = DATA;
      end
      TAIL: begin
        if (take_tail && tail_done) next_state = DRAIN;
        else                        next_state = TAIL;
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) next_state = IDLE;
        else                                    next_state = DRAIN;
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame configuration, encoder shift register, counters and output beat register.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_state <= '0;
      len_r     <= '0;
      cnt       <= '0;
      tail_cnt  <= '0;
      mode_r    <= 2'd0;
      phase     <= 2'd0;
      tb_r      <= 1'b0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_mask  <= 2'b00;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        len_r     <= (frame_len == {LEN_W{1'b0}}) ? LEN_W'(1) : frame_len;
        mode_r    <= mode;
        tb_r      <= tail_biting;
        enc_state <= tail_biting ? seed_value : {M{1'b0}};
        cnt       <= '0;
        tail_cnt  <= '0;
        phase     <= 2'd0;
      end else if (gen) begin
        enc_state <= {gen_bit, enc_state[M-1:1]};
        if (take_data) begin
          cnt   <= cnt + LEN_W'(1);
          phase <= phase_next(mode_r, phase);
        end else begin
          tail_cnt <= tail_cnt + TW'(1);
        end
      end

      if (gen) begin
        out_valid <= 1'b1;
        out_sym   <= sym_raw & mask_s;
        out_mask  <= mask_s;
        out_last  <= beat_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sym   <= 2'b00;
        out_mask  <= 2'b00;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
